// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - instruction memory write port driven by the boot loader
interface imem_loader_if;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;

    modport master (output imem_we, output imem_addr, output imem_wdata);
    modport slave  (input  imem_we, input  imem_addr, input  imem_wdata);
endinterface

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - UART boot loader that fills instruction memory while holding the CPU
module imem_loader #(
    parameter int CLKS_PER_BIT = 434,
    parameter int MAX_WORDS    = 256
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                rx,
    imem_loader_if.master       imem,
    output logic                cpu_hold,
    output logic                load_done,
    output logic                load_err,
    output logic [15:0]         words_loaded
);

    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_M1  = CW'(CLKS_PER_BIT - 1);

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    localparam logic [2:0] LD_IDLE   = 3'd0;
    localparam logic [2:0] LD_LEN_LO = 3'd1;
    localparam logic [2:0] LD_LEN_HI = 3'd2;
    localparam logic [2:0] LD_DATA   = 3'd3;
    localparam logic [2:0] LD_WRITE  = 3'd4;
    localparam logic [2:0] LD_DONE   = 3'd5;
    localparam logic [2:0] LD_ERR    = 3'd6;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    logic          rx_meta_q, rx_sync_q, rx_prev_q;
    logic [1:0]    rx_state_q, rx_state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          byte_valid, frame_err;

    logic [2:0]    ld_state_q, ld_state_d;
    logic [15:0]   n_q, n_d;
    logic [15:0]   n_new;
    logic [15:0]   widx_q, widx_d;
    logic [15:0]   wl_q, wl_d;
    logic [1:0]    bidx_q, bidx_d;
    logic [31:0]   word_q, word_d;
    logic          hold_q, hold_d;
    logic          err_q, err_d;

    // Synchronizer idles high so reset release never looks like a start edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        byte_valid = 1'b0;
        frame_err  = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (!rx_sync_q && rx_prev_q) begin
                    rx_state_d = RX_START;
                    cnt_d      = HALF_M1;
                end
            end
            RX_START: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (rx_sync_q) begin
                    rx_state_d = RX_IDLE;
                end else begin
                    rx_state_d = RX_DATA;
                    cnt_d      = BIT_M1;
                    bit_d      = 3'd0;
                end
            end
            RX_DATA: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    shift_d = {rx_sync_q, shift_q[7:1]};
                    cnt_d   = BIT_M1;
                    if (bit_q == 3'd7) rx_state_d = RX_STOP;
                    else               bit_d      = bit_q + 3'd1;
                end
            end
            default: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    byte_valid = rx_sync_q;
                    frame_err  = !rx_sync_q;
                    rx_state_d = RX_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_state_q <= RX_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
        end else begin
            rx_state_q <= rx_state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
        end
    end

    assign n_new = {shift_q, n_q[7:0]};

    always_comb begin
        ld_state_d = ld_state_q;
        n_d        = n_q;
        widx_d     = widx_q;
        wl_d       = wl_q;
        bidx_d     = bidx_q;
        word_d     = word_q;
        hold_d     = hold_q;
        err_d      = err_q;
        case (ld_state_q)
            LD_IDLE: begin
                if (byte_valid && shift_q == SYNC_BYTE) begin
                    ld_state_d = LD_LEN_LO;
                    err_d      = 1'b0;
                    wl_d       = '0;
                    hold_d     = 1'b1;
                end
            end
            LD_LEN_LO: begin
                if (frame_err) begin
                    ld_state_d = LD_ERR;
                    err_d      = 1'b1;
                end else if (byte_valid) begin
                    n_d[7:0]   = shift_q;
                    ld_state_d = LD_LEN_HI;
                end
            end
            LD_LEN_HI: begin
                if (frame_err) begin
                    ld_state_d = LD_ERR;
                    err_d      = 1'b1;
                end else if (byte_valid) begin
                    n_d = n_new;
                    if (n_new == 16'd0 || n_new > 16'(MAX_WORDS)) begin
                        ld_state_d = LD_ERR;
                        err_d      = 1'b1;
                    end else begin
                        ld_state_d = LD_DATA;
                        bidx_d     = 2'd0;
                        widx_d     = '0;
                    end
                end
            end
            LD_DATA: begin
                if (frame_err) begin
                    ld_state_d = LD_ERR;
                    err_d      = 1'b1;
                end else if (byte_valid) begin
                    word_d[bidx_q*8 +: 8] = shift_q;
                    bidx_d = bidx_q + 2'd1;
                    if (bidx_q == 2'd3) ld_state_d = LD_WRITE;
                end
            end
            LD_WRITE: begin
                widx_d = widx_q + 16'd1;
                wl_d   = wl_q + 16'd1;
                if (widx_q + 16'd1 == n_q) begin
                    ld_state_d = LD_DONE;
                    hold_d     = 1'b0;
                end else begin
                    ld_state_d = LD_DATA;
                end
            end
            default: ld_state_d = LD_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ld_state_q <= LD_IDLE;
            n_q        <= '0;
            widx_q     <= '0;
            wl_q       <= '0;
            bidx_q     <= '0;
            word_q     <= '0;
            hold_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            ld_state_q <= ld_state_d;
            n_q        <= n_d;
            widx_q     <= widx_d;
            wl_q       <= wl_d;
            bidx_q     <= bidx_d;
            word_q     <= word_d;
            hold_q     <= hold_d;
            err_q      <= err_d;
        end
    end

    assign imem.imem_we    = (ld_state_q == LD_WRITE);
    assign imem.imem_addr  = imem.imem_we ? {14'd0, widx_q, 2'b00} : 32'd0;
    assign imem.imem_wdata = imem.imem_we ? word_q : 32'd0;
    assign load_done       = (ld_state_q == LD_DONE);
    assign cpu_hold        = hold_q;
    assign load_err        = err_q;
    assign words_loaded    = wl_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed bench for imem_loader with CLKS_PER_BIT=4, MAX_WORDS=4
module tb_imem_loader;

    localparam int CPB = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        rx_pin = 1'b1;
    logic        cpu_hold, load_done, load_err;
    logic [15:0] words_loaded;

    imem_loader_if bus ();

    imem_loader #(.CLKS_PER_BIT(CPB), .MAX_WORDS(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .rx           (rx_pin),
        .imem         (bus),
        .cpu_hold     (cpu_hold),
        .load_done    (load_done),
        .load_err     (load_err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail = 0;
    int          wr_cnt = 0;
    int          done_cnt = 0;
    int          b2b_cnt = 0;
    int          idle_bus_cnt = 0;
    logic        we_prev = 1'b0;
    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    logic [7:0]  bq[$];

    always @(negedge clk) begin
        if (bus.imem_we) begin
            wr_addr.push_back(bus.imem_addr);
            wr_data.push_back(bus.imem_wdata);
            wr_cnt <= wr_cnt + 1;
        end else if (bus.imem_addr != 32'd0 || bus.imem_wdata != 32'd0) begin
            idle_bus_cnt <= idle_bus_cnt + 1;
        end
        if (bus.imem_we && we_prev) b2b_cnt <= b2b_cnt + 1;
        we_prev <= bus.imem_we;
        if (load_done) done_cnt <= done_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send_bit(input logic v);
        rx_pin = v;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        @(posedge clk);
        #1;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop_bit);
        rx_pin = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic send_bytes();
        for (int i = 0; i < bq.size(); i++) send_byte(bq[i], 1'b1);
    endtask

    task automatic settle();
        repeat (8) @(posedge clk);
        @(negedge clk);
    endtask

    int w0, d0;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_we", {31'd0, bus.imem_we}, 32'd0);
        chk("rst_hold", {31'd0, cpu_hold}, 32'd0);
        chk("rst_err", {31'd0, load_err}, 32'd0);
        chk("rst_wl", {16'd0, words_loaded}, 32'd0);
        reset = 1'b1;
        repeat (4) @(posedge clk);

        // Nominal two-word load
        w0 = wr_cnt; d0 = done_cnt;
        send_byte(8'hA5, 1'b1);
        @(negedge clk);
        chk("nom_hold_after_sync", {31'd0, cpu_hold}, 32'd1);
        bq = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        send_bytes();
        settle();
        chk("nom_nwr", wr_cnt - w0, 2);
        if (wr_cnt - w0 == 2) begin
            chk("nom_addr0", wr_addr[w0], 32'h0);
            chk("nom_data0", wr_data[w0], 32'h12345678);
            chk("nom_addr1", wr_addr[w0+1], 32'h4);
            chk("nom_data1", wr_data[w0+1], 32'hDEADBEEF);
        end
        chk("nom_done", done_cnt - d0, 1);
        chk("nom_wl", {16'd0, words_loaded}, 32'd2);
        chk("nom_hold_end", {31'd0, cpu_hold}, 32'd0);
        chk("nom_err", {31'd0, load_err}, 32'd0);

        // Noise before sync
        w0 = wr_cnt;
        bq = '{8'h00, 8'hFF, 8'h5A};
        send_bytes();
        settle();
        chk("noise_hold", {31'd0, cpu_hold}, 32'd0);
        chk("noise_nwr", wr_cnt - w0, 0);
        bq = '{8'hA5, 8'h01, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00};
        send_bytes();
        settle();
        chk("noise_frame_nwr", wr_cnt - w0, 1);
        if (wr_cnt - w0 == 1) begin
            chk("noise_addr", wr_addr[w0], 32'h0);
            chk("noise_data", wr_data[w0], 32'h00000001);
        end
        chk("noise_wl", {16'd0, words_loaded}, 32'd1);

        // Bad length: zero, then above maximum
        w0 = wr_cnt;
        bq = '{8'hA5, 8'h00, 8'h00};
        send_bytes();
        settle();
        chk("len0_err", {31'd0, load_err}, 32'd1);
        chk("len0_hold", {31'd0, cpu_hold}, 32'd1);
        chk("len0_wl", {16'd0, words_loaded}, 32'd0);
        send_byte(8'hA5, 1'b1);
        @(negedge clk);
        chk("sync_clears_err", {31'd0, load_err}, 32'd0);
        bq = '{8'h05, 8'h00};
        send_bytes();
        settle();
        chk("len5_err", {31'd0, load_err}, 32'd1);
        chk("bad_len_nwr", wr_cnt - w0, 0);
        bq = '{8'hA5, 8'h01, 8'h00, 8'h0D, 8'hF0, 8'hFE, 8'hCA};
        send_bytes();
        settle();
        chk("recover_err", {31'd0, load_err}, 32'd0);
        chk("recover_hold", {31'd0, cpu_hold}, 32'd0);
        chk("recover_nwr", wr_cnt - w0, 1);
        if (wr_cnt - w0 == 1) chk("recover_data", wr_data[w0], 32'hCAFEF00D);

        // Length at the maximum is accepted
        bq = '{8'hA5, 8'h04, 8'h00};
        send_bytes();
        settle();
        chk("len4_err", {31'd0, load_err}, 32'd0);
        chk("len4_hold", {31'd0, cpu_hold}, 32'd1);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        // Framing error in data
        w0 = wr_cnt;
        bq = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22};
        send_bytes();
        send_byte(8'h33, 1'b0);
        settle();
        chk("ferr_err", {31'd0, load_err}, 32'd1);
        chk("ferr_nwr", wr_cnt - w0, 0);
        chk("ferr_wl", {16'd0, words_loaded}, 32'd0);
        chk("ferr_hold", {31'd0, cpu_hold}, 32'd1);

        // Reset mid-word: outputs clear without a clock edge
        bq = '{8'hA5, 8'h01, 8'h00, 8'hAA};
        send_bytes();
        #2 reset = 1'b0;
        #1;
        chk("arst_hold", {31'd0, cpu_hold}, 32'd0);
        chk("arst_err", {31'd0, load_err}, 32'd0);
        chk("arst_we", {31'd0, bus.imem_we}, 32'd0);
        chk("arst_wl", {16'd0, words_loaded}, 32'd0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        w0 = wr_cnt; d0 = done_cnt;
        bq = '{8'hA5, 8'h01, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11};
        send_bytes();
        settle();
        chk("arst_nwr", wr_cnt - w0, 1);
        if (wr_cnt - w0 == 1) begin
            chk("arst_addr", wr_addr[w0], 32'h0);
            chk("arst_data", wr_data[w0], 32'h11223344);
        end
        chk("arst_done", done_cnt - d0, 1);

        // Start glitch of one cycle in idle
        w0 = wr_cnt;
        @(posedge clk);
        #1 rx_pin = 1'b0;
        @(posedge clk);
        #1 rx_pin = 1'b1;
        repeat (60) @(posedge clk);
        @(negedge clk);
        chk("glitch_nwr", wr_cnt - w0, 0);
        chk("glitch_hold", {31'd0, cpu_hold}, 32'd0);
        chk("glitch_wl", {16'd0, words_loaded}, 32'd1);
        bq = '{8'hA5, 8'h01, 8'h00, 8'h0D, 8'hD0, 8'hFE, 8'hC0};
        send_bytes();
        settle();
        chk("glitch_frame_nwr", wr_cnt - w0, 1);
        if (wr_cnt - w0 == 1) chk("glitch_frame_data", wr_data[w0], 32'hC0FED00D);

        chk("no_b2b_writes", b2b_cnt, 0);
        chk("bus_zero_when_idle", idle_bus_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Serial boot loader that writes a program image into the instruction memory write port while holding the processor datapath off. It receives 8N1 UART bytes on a single `rx` line, parses a framed image (sync byte, word count, little-endian words) and issues one word write per received word. It is the write-side counterpart of the datapath's instruction fetch: the datapath reads instruction memory by `pc`, and this block fills it. `cpu_hold` is intended to be ORed into the datapath reset.

## Interface
Parameters:
- `CLKS_PER_BIT`, 434: clock cycles per UART bit (50 MHz / 115200); must be ≥ 4.
- `MAX_WORDS`, 256: largest accepted image in 32-bit words.

Ports:
- `clk`  in  1  single system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `rx`  in  1  UART serial input, idle high, asynchronous to `clk`.
- `imem_we`  out  1  instruction memory write strobe, one cycle per word.
- `imem_addr`  out  32  byte address of the write, word-aligned.
- `imem_wdata`  out  32  word to write.
- `cpu_hold`  out  1  high while a load is in progress or has failed.
- `load_done`  out  1  one-cycle pulse on successful completion.
- `load_err`  out  1  sticky error flag.
- `words_loaded`  out  16  words written in the current or last load.

## Operation
- `reset` low: all outputs 0, FSM in IDLE, receiver idle, synchronizer flops set to 1. Memory contents already written are not affected.
- `rx` passes through a 2-flop synchronizer. All references to `rx` below mean the synchronized value.
- **Receiver:**
  - A 1→0 transition starts a candidate start bit.
  - `rx` is sampled floor(`CLKS_PER_BIT`/2) cycles after that edge. If the sample is 1, it is a glitch: return to idle with no byte.
  - Then 8 data bits (LSB first) and 1 stop bit are sampled, every `CLKS_PER_BIT` cycles.
  - Stop sample = 1: internal `byte_valid` pulses for one cycle in the stop-sample cycle.
  - Stop sample = 0: internal `frame_err` pulses instead.
  - The receiver returns to idle immediately after the stop sample.
- **Loader FSM:**
  - IDLE: byte 0xA5 → LEN_LO, clear `load_err` and `words_loaded`, set `cpu_hold` = 1. Any other byte and any `frame_err` are ignored.
  - LEN_LO: the byte becomes N[7:0] → LEN_HI.
  - LEN_HI: the byte becomes N[15:8]. If N = 0 or N > `MAX_WORDS` → ERR, else DATA with byte index 0 and word index 0.
  - DATA: each byte is placed in word bits [8k+7:8k] for k = 0..3. After the 4th byte → WRITE.
  - WRITE (one cycle):
    - Drive `imem_we` = 1, `imem_addr` = word index × 4, `imem_wdata` = assembled word.
    - Increment the word index and `words_loaded`.
    - If the new index = N → DONE, else DATA.
  - DONE (one cycle): `load_done` = 1, `cpu_hold` = 0 → IDLE.
  - ERR (one cycle): `load_err` = 1, `cpu_hold` stays 1 → IDLE.
  - `frame_err` in LEN_LO, LEN_HI or DATA → ERR. The partial word is discarded.
- `load_err` and a held `cpu_hold` persist until the next accepted sync byte or `reset`. A partial image never runs.
- `imem_addr` and `imem_wdata` are 0 whenever `imem_we` = 0.

## Timing
- First data-bit sample: floor(`CLKS_PER_BIT`/2) + `CLKS_PER_BIT` cycles after the synchronized start edge.
- Stop sample (`byte_valid`): floor(`CLKS_PER_BIT`/2) + 9·`CLKS_PER_BIT` cycles after the synchronized start edge.
- Synchronizer latency: 2 cycles from pin to synchronized `rx`.
- Sync byte: `cpu_hold` rises in the cycle after its `byte_valid`.
- 4th data byte: `imem_we` is high in the cycle after its `byte_valid`, for exactly 1 cycle. There is one write per word, and writes are never back-to-back.
- Last write: `load_done` pulses the cycle after the last `imem_we`, and `cpu_hold` falls in that same cycle.
- Error: `load_err` rises the cycle after the offending `byte_valid` or `frame_err`.
- `words_loaded` updates in the WRITE cycle and is otherwise held.
- Reset mid-frame: outputs go to 0 asynchronously, without waiting for a clock edge. The next frame after deassertion loads normally.

## Test plan
All scenarios use `CLKS_PER_BIT` = 4 and `MAX_WORDS` = 4.
- **Nominal load.** Send A5 02 00 78 56 34 12 EF BE AD DE.
  - Writes (0x0, 0x12345678) then (0x4, 0xDEADBEEF), each 1 cycle.
  - `load_done` pulses once, `words_loaded` = 2, `cpu_hold` 1→0.
- **Noise before sync.** Send 00 FF 5A, then the frame A5 01 00 01 00 00 00.
  - No writes and no `cpu_hold` before A5.
  - Then a single write (0x0, 0x00000001).
- **Bad length.** Send A5 00 00.
  - `load_err` = 1, no `imem_we`, `cpu_hold` stays 1.
  - Send A5 05 00: `load_err` = 1 again.
  - Then a valid 1-word frame: `load_err` clears, `cpu_hold` falls.
- **Framing error in data.** Send A5 01 00 11 22, then the third byte with stop bit = 0.
  - `load_err` = 1, no `imem_we`, `words_loaded` = 0, `cpu_hold` = 1.
- **Reset mid-word.** Pull `reset` low after A5 01 00 AA.
  - All outputs are 0 immediately.
  - After release, the full frame A5 01 00 44 33 22 11 writes (0x0, 0x11223344).
- **Start glitch.** Drive `rx` low for 1 cycle in idle.
  - No byte is received, the state is unchanged, and the following valid frame loads correctly.
